// File: rtl/priority_arbiter_tgco_pkg.sv
// Shared types and constants for the tgco priority arbiter.
// Grant codes are one-based, with zero meaning "no grant".
package tgco_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int GRANT_NONE = 0;

  // Supported requester count range.
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

endpackage

// File: rtl/priority_arbiter_tgco_if.sv
// Requester/arbiter bundle for priority_arbiter_tgco.
// Handshake: req is level-sensitive. release_grant is honoured only while
// grant_valid=1. All grant outputs are registered and change one cycle
// after the edge that sampled the deciding inputs.
interface priority_arbiter_tgco_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N + 1);

  logic [N-1:0] req;
  logic         mode;
  // Named release_grant because "release" is a reserved word.
  logic         release_grant;
  logic         grant_valid;
  logic [W-1:0] grant_code;
  logic [N-1:0] grant_onehot;
  logic         timeout;

  modport master (
    output req, mode, release_grant,
    input  grant_valid, grant_code, grant_onehot, timeout
  );

  modport slave (
    input  req, mode, release_grant,
    output grant_valid, grant_code, grant_onehot, timeout
  );
endinterface

// File: rtl/priority_arbiter_tgco_pick.sv
// Combinational winner search: rotate so ptr sits at the top, take the
// highest set bit, map back. Fixed mode is the same search anchored at N-1.
module priority_pick_tgco #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic          found,
  output logic [IW-1:0] win
);

  logic [IW-1:0] anchor;

  assign anchor = mode ? ptr : IW'(N - 1);

  always_comb begin
    found = 1'b0;
    win   = '0;
    // Ascending scan; the last hit is the highest rotated position.
    for (int j = 0; j < N; j++) begin
      int s;
      s = j + int'(anchor) + 1;
      if (s >= N) s = s - N;
      if (cand[s]) begin
        found = 1'b1;
        win   = IW'(s);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_tgco.sv
// Registered N-way priority arbiter with fixed/round-robin selection,
// grant hold until release, and a hold timeout.
module priority_arbiter_tgco
  import tgco_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  priority_arbiter_tgco_if.slave   bus,
  output state_t                   dbg_state
);

  localparam int W         = $clog2(N + 1);
  localparam int IW        = $clog2(N);
  localparam int CW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam int HOLD_SAT  = (MAX_HOLD > 0) ? MAX_HOLD : 0;

  state_t        state;
  logic [IW-1:0] holder;
  logic [IW-1:0] ptr;
  logic [CW-1:0] hold_cnt;
  logic          gv_q;
  logic [W-1:0]  code_q;
  logic [N-1:0]  onehot_q;
  logic          timeout_q;

  logic          holder_req;
  logic          timeout_hit;
  logic          end_of_grant;
  logic          arbitrate;
  logic [N-1:0]  cand;
  logic          found;
  logic [IW-1:0] win;

  assign holder_req   = bus.req[holder];
  assign timeout_hit  = (MAX_HOLD != 0) && (hold_cnt == CW'(HOLD_LAST));
  assign end_of_grant = (state == ST_GRANT) &&
                        (bus.release_grant || !holder_req || timeout_hit);
  assign arbitrate    = (state == ST_IDLE) || end_of_grant;
  // The outgoing holder is excluded only for the arbitration that ends it.
  assign cand         = (state == ST_IDLE) ? bus.req : (bus.req & ~onehot_q);

  priority_pick_tgco #(.N(N), .IW(IW)) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .mode  (bus.mode),
    .found (found),
    .win   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      holder    <= '0;
      ptr       <= IW'(N - 1);
      hold_cnt  <= '0;
      gv_q      <= 1'b0;
      code_q    <= W'(GRANT_NONE);
      onehot_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (arbitrate) begin
        hold_cnt <= '0;
        if (end_of_grant && timeout_hit && !bus.release_grant && holder_req)
          timeout_q <= 1'b1;
        if (found) begin
          state    <= ST_GRANT;
          holder   <= win;
          ptr      <= (win == '0) ? IW'(N - 1) : win - 1'b1;
          gv_q     <= 1'b1;
          code_q   <= W'(win) + W'(1);
          onehot_q <= N'(1) << win;
        end else begin
          state    <= ST_IDLE;
          gv_q     <= 1'b0;
          code_q   <= W'(GRANT_NONE);
          onehot_q <= '0;
        end
      end else if (hold_cnt != CW'(HOLD_SAT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign bus.grant_valid  = gv_q;
  assign bus.grant_code   = code_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.timeout      = timeout_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_priority_arbiter_tgco.sv
// Directed bench for priority_arbiter_tgco (N=4, MAX_HOLD=8) with
// hand-computed expectations checked by immediate assertions.
module tb_priority_arbiter_tgco;
  import tgco_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     total = 0;
  int     pass_cnt = 0;
  int     fail_cnt = 0;

  priority_arbiter_tgco_if #(.N(4)) bus ();

  priority_arbiter_tgco #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic gv, input logic [2:0] code,
                             input logic [3:0] oh, input logic to);
    check({tag, "_valid"},   32'(bus.grant_valid),  32'(gv));
    check({tag, "_code"},    32'(bus.grant_code),   32'(code));
    check({tag, "_onehot"},  32'(bus.grant_onehot), 32'(oh));
    check({tag, "_timeout"}, 32'(bus.timeout),      32'(to));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.mode = 1'b0;
    bus.release_grant = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rr_exp [5];
    rr_exp = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd4};

    // Reset with every requester active.
    bus.req = 4'b1111;
    bus.mode = 1'b0;
    bus.release_grant = 1'b0;
    step();
    step();
    check_grant("reset", 1'b0, 3'd0, 4'b0000, 1'b0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();
    check_grant("first_after_reset", 1'b1, 3'd4, 4'b1000, 1'b0);
    check("grant_state", 32'(dbg_state), 32'(ST_GRANT));

    // Fixed priority with back-to-back handover on release.
    do_reset();
    bus.req = 4'b0101;
    step();
    check_grant("fixed_first", 1'b1, 3'd3, 4'b0100, 1'b0);
    bus.release_grant = 1'b1;
    step();
    check_grant("fixed_handover", 1'b1, 3'd1, 4'b0001, 1'b0);
    bus.release_grant = 1'b0;
    step();
    check_grant("fixed_hold", 1'b1, 3'd1, 4'b0001, 1'b0);

    // Round robin, releasing on every granted cycle.
    do_reset();
    bus.req = 4'b1111;
    bus.mode = 1'b1;
    bus.release_grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_code_%0d", i), 32'(bus.grant_code), 32'(rr_exp[i]));
      check($sformatf("rr_valid_%0d", i), 32'(bus.grant_valid), 32'd1);
    end
    bus.release_grant = 1'b0;

    // Timeout with a single persistent requester.
    do_reset();
    bus.req = 4'b1000;
    step();
    for (int i = 0; i < 8; i++) begin
      check_grant($sformatf("hold_%0d", i), 1'b1, 3'd4, 4'b1000, 1'b0);
      step();
    end
    check_grant("timeout_pulse", 1'b0, 3'd0, 4'b0000, 1'b1);
    check("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check_grant("regrant", 1'b1, 3'd4, 4'b1000, 1'b0);

    // Implicit release when the holder drops its request.
    do_reset();
    bus.req = 4'b0110;
    step();
    check_grant("implicit_first", 1'b1, 3'd3, 4'b0100, 1'b0);
    bus.req = 4'b0010;
    step();
    check_grant("implicit_next", 1'b1, 3'd2, 4'b0010, 1'b0);
    bus.req = 4'b0000;
    step();
    check_grant("implicit_idle", 1'b0, 3'd0, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    bus.req = 4'b0100;
    step();
    check_grant("async_pre", 1'b1, 3'd3, 4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_grant("async_clear", 1'b0, 3'd0, 4'b0000, 1'b0);
    bus.req = 4'b1111;
    bus.mode = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    check_grant("async_regrant", 1'b1, 3'd4, 4'b1000, 1'b0);
    bus.release_grant = 1'b1;
    step();
    check_grant("async_rr_next", 1'b1, 3'd3, 4'b0100, 1'b0);
    bus.release_grant = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_tgco.md
# priority_arbiter_tgco

Parametrised, registered priority arbiter that generalises the four-input priority encoder to N requesters. It can run in fixed-priority or round-robin mode, holds a grant until release, and enforces a hold timeout. The grant code keeps the existing one-based encoding (0 = no grant, k+1 = requester k), so downstream decode logic is unchanged. The block arbitrates shared resources in the combo datapath.

## Interface
- N, default 4: requester count, legal 2..16.
- MAX_HOLD, default 8: maximum cycles a grant may be held; 0 disables the timeout.
- W, derived as $clog2(N+1): grant code width; not overridable.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request lines; bit k = requester k.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round robin.
- release  input  1  holder finished; valid only while grant_valid=1.
- grant_valid  output  1  a grant is active.
- grant_code  output  W  one-based index of the holder; 0 when idle.
- grant_onehot  output  N  one-hot holder; all zero when idle.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States are IDLE and GRANT.
- Reset (async, rst_n=0) forces:
  - state=IDLE; all outputs 0.
  - hold counter=0.
  - round-robin pointer ptr=N-1.
- Arbitration is performed in IDLE every cycle, and in GRANT only at an end-of-grant event.
- mode is sampled only at arbitration.
- Fixed priority: the highest set index of the candidate vector wins.
- Round robin: search starts at ptr and descends with wrap (ptr, ptr-1, …, 0, N-1, …). After granting k, ptr ← (k-1) mod N.
  - ptr updates in fixed mode too, so a later switch to round robin is fair.
- Candidate vector:
  - In IDLE: req.
  - At an end-of-grant event: req with the holder's bit masked for that arbitration only.
- End-of-grant events while in GRANT:
  - release=1;
  - req[holder]=0 (implicit release);
  - hold counter reaches MAX_HOLD-1 without release (timeout; asserts timeout for the next cycle).
- Simultaneous events are a single end-of-grant. timeout pulses only if release=0 and req[holder]=1 on that cycle.
- At an end-of-grant event:
  - If the candidate vector is non-zero, switch directly to the new winner (back-to-back, no idle cycle) and clear the hold counter.
  - If it is zero, go to IDLE.
- Hold counter:
  - Increments each GRANT cycle without an end-of-grant event.
  - Width is $clog2(MAX_HOLD+1).
  - Saturates and never wraps.
  - Unused when MAX_HOLD=0.
- release in IDLE is ignored.
- req bits are level-sensitive; no latching of transient requests.

## Timing
- All outputs are registered; no combinational input→output path.
- IDLE with req≠0 sampled at edge t gives grant_valid=1 and code/onehot at t+1.
- End-of-grant sampled at edge t:
  - new grant or idle outputs appear at t+1;
  - timeout is high during cycle t+1 only.
- Maximum continuous hold is MAX_HOLD cycles of grant_valid=1 for one holder.
- After a timeout, a holder that is the only requester gets one IDLE cycle, then is regranted.
- rst_n assertion mid-grant clears outputs immediately (asynchronous). Deassertion is synchronised by the system; the first arbitration happens on the first edge after release of reset.

## Structure
- Package tgco_arb_pkg holds:
  - the state encoding (IDLE=1'b0, GRANT=1'b1);
  - GRANT_NONE=0;
  - the N legality bounds.
- Sub-module priority_pick_tgco is combinational. It takes the candidate vector, ptr, and mode, and returns a found flag plus a winner index. It rotates by ptr, priority-encodes from the high end, and un-rotates.
- The top level holds the FSM, hold counter, ptr, output registers, and index→one-based code and one-hot conversion.

## Test plan
- Reset: rst_n=0 with req=4'b1111 → grant_valid=0, grant_code=0, grant_onehot=0, timeout=0. First edge after release → grant_code=4.
- Fixed (N=4, mode=0): req=4'b0101 → next cycle grant_code=3, onehot=4'b0100. Then release=1 with req unchanged → next cycle grant_code=1 with no idle gap.
- Round robin (mode=1): req=4'b1111 held, release pulsed on every granted cycle → grant_code sequence 4,3,2,1,4.
- Timeout (MAX_HOLD=8): req=4'b1000 held, release=0:
  - grant_code=4 for 8 cycles;
  - timeout=1 with grant_valid=0 for one cycle;
  - then grant_code=4 again.
- Implicit release: holder 2 granted (req=4'b0110), then req→4'b0010 → next cycle grant_code=2, timeout=0.
- Async reset mid-grant: rst_n pulled low between edges while grant_code=3 → outputs 0 immediately; ptr back to 3 (the first grant after reset follows fixed order).
